uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
// - Parametrised UART receiver: oversampled, mid-bit sampling; successor to the one-bit-per-clock uart_rx.
// - Configurable data width, parity and stop bits; 2-flop input synchroniser; false-start rejection.
// - Reports parity and framing errors. Sits between the async serial pin and the byte-level datapath.
// PARAMETERS
// - CLKS_PER_BIT  16  clk cycles per serial bit; even, >= 4
// - DATA_BITS     8   data bits per frame, 5..9, LSB first
// - PARITY_MODE   0   0 = none, 1 = even, 2 = odd
// - STOP_BITS     1   stop bits checked, 1 or 2
// PORTS
// - clk         in   1          system clock, all logic on rising edge
// - rst         in   1          asynchronous, active-low reset (0 = reset)
// - rx          in   1          serial line, idle high, asynchronous to clk
// - rx_data     out  DATA_BITS  last received word
// - rx_done     out  1          one-cycle pulse: rx_data, parity_err and frame_err valid
// - parity_err  out  1          parity mismatch on last frame; 0 when PARITY_MODE = 0
// - frame_err   out  1          a stop bit was sampled low on last frame
// - busy        out  1          high in every state except IDLE
// BEHAVIOUR
// - Reset (rst = 0, async): state = IDLE; synchroniser flops = 1; all outputs 0; counters 0.
// - rx passes through 2 flops (rx_s); all decisions use rx_s. This adds 2 cycles of latency.
// - Bit counter cnt runs 0..CLKS_PER_BIT-1; a sample is taken when cnt = CLKS_PER_BIT-1.
// - States and transitions:
//   - IDLE: on rx_s = 0, go to START with cnt = 0.
//   - START: at cnt = CLKS_PER_BIT/2-1, sample rx_s.
//     - 1 = glitch: back to IDLE, no rx_done.
//     - 0 = valid start: go to DATA with cnt = 0.
//   - DATA: sample every CLKS_PER_BIT cycles, shift in LSB first.
//     - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
//   - PARITY: one sample. Error if XOR(data, bit) = 1 (even mode) or 0 (odd mode).
//   - STOP: STOP_BITS samples. Any low sample sets the frame error. After the last sample go to DONE.
//   - DONE (1 cycle):
//     - rx_done = 1; rx_data, parity_err and frame_err are loaded.
//     - Next state is IDLE, or BREAK if a frame error occurred.
//   - BREAK: wait for rx_s = 1, then IDLE. A line held low never re-triggers START.
// - rx_done is high for exactly one cycle, on the cycle after the final stop-bit sample.
// - rx_data, parity_err and frame_err hold their values until the next DONE.
// - A frame with errors still updates rx_data and still pulses rx_done.
// - Back-to-back frames: a start edge sampled in the IDLE cycle right after DONE is accepted.
//   No extra gap is required.
// - Reset mid-frame aborts immediately and the partial word is discarded.
// CONFIGURATION
// - UART_RX_MAJORITY_EN defined:
//   - Each bit value is the majority of rx_s taken at the mid-point sample and the samples one cycle before and after it.
//   - This also applies to the start-bit check, so a single-cycle glitch at the sample point is filtered.
//   - rx_done timing is unchanged, except a 1-cycle shift from the final vote register, which applies to all frames equally.
// - Undefined: single sample at the mid-point. No extra registers.
// TESTING
// - All cases use CLKS_PER_BIT=16 unless stated.
// - 8N1, send 0xA5 -> exactly one rx_done pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy low after.
// - PARITY_MODE=1, send 0x3C with parity bit 1 (wrong) -> rx_done, rx_data=0x3C, parity_err=1;
//   next frame 0x3C with parity bit 0 -> parity_err=0.
// - Stop bit driven 0, line held low 100 cycles, then high -> frame_err=1, a single rx_done, no further rx_done;
//   then frame 0x5A -> rx_data=0x5A, frame_err=0.
// - 4-cycle low glitch on idle line -> no rx_done, busy returns 0 within CLKS_PER_BIT/2+3 cycles.
//   With UART_RX_MAJORITY_EN, a 1-cycle glitch at the sample point is also rejected.
// - rst=0 in middle of DATA of frame 0xFF -> all outputs 0 immediately; after release, frame 0x81 -> rx_data=0x81.
// - Back-to-back 0x00, 0xFF, 0x55 (no idle gap) -> three rx_done pulses with those values, no errors;
//   repeat with DATA_BITS=7, STOP_BITS=2, PARITY_MODE=2.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Serial-line / received-word bundle for uart_rx_os.
// The master side is the receiver; the slave side drives the line and consumes words.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output rx_data, rx_done, parity_err, frame_err, busy);
  modport slave  (output rx, input rx_data, rx_done, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 2-flop sync, mid-bit sampling, false-start rejection, parity/framing checks.
// Define UART_RX_MAJORITY_EN to make every bit decision a 3-sample majority vote.
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic          clk,
  input logic          rst,
  uart_rx_os_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAK} state_t;
  state_t state, state_nxt;

  logic                 rx_m, rx_s, smp, tick;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg, rx_data_q;
  logic                 par_acc, perr_acc, ferr_acc;
  logic                 parity_err_q, frame_err_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) {rx_m, rx_s} <= 2'b11;
    else      {rx_m, rx_s} <= {bus.rx, rx_m};

`ifdef UART_RX_MAJORITY_EN
  // Vote window is rx_s over three consecutive cycles, centred on rx_d1.
  logic rx_d1, rx_d2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {rx_d1, rx_d2} <= 2'b11;
    else      {rx_d1, rx_d2} <= {rx_s, rx_d1};
  assign smp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign smp = rx_s;
`endif

  // Start bit is checked at its half-period; all other bits a full period later.
  assign tick = (state == START) ? (cnt == CW'(CLKS_PER_BIT/2 - 1))
                                 : (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (tick) state_nxt = smp ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == BW'(DATA_BITS - 1))
                 state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick && stop_cnt == 1'(STOP_BITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = frame_err_q ? BREAK : IDLE;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt != state || tick) cnt <= '0;
      else                                              cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          par_acc  <= 1'b0;
          perr_acc <= 1'b0;
          ferr_acc <= 1'b0;
        end
        DATA: if (tick) begin
          shreg   <= {smp, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ smp;
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (tick) perr_acc <= (PARITY_MODE == 1) ? (par_acc ^ smp) : ~(par_acc ^ smp);
        STOP: if (tick) begin
          stop_cnt <= stop_cnt + 1'b1;
          if (!smp) ferr_acc <= 1'b1;
        end
        default: ;
      endcase
      // Results land on the edge into DONE so they are valid alongside rx_done.
      if (state == STOP && state_nxt == DONE) begin
        rx_data_q    <= shreg;
        parity_err_q <= perr_acc;
        frame_err_q  <= ferr_acc | ~smp;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_done    = (state == DONE);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 8E1 and 7O2 receivers sharing one clock and reset.
module tb_uart_rx_os;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_os_if #(.DATA_BITS(8)) ifa ();
  uart_rx_os_if #(.DATA_BITS(8)) ifb ();
  uart_rx_os_if #(.DATA_BITS(7)) ifc ();

  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int tests = 0;
  int fails = 0;

  // {parity_err, frame_err, data zero-extended to 9 bits}
  logic [10:0] q_a[$], q_b[$], q_c[$];

  always @(negedge clk) begin
    if (ifa.rx_done) q_a.push_back({ifa.parity_err, ifa.frame_err, 1'b0, ifa.rx_data});
    if (ifb.rx_done) q_b.push_back({ifb.parity_err, ifb.frame_err, 1'b0, ifb.rx_data});
    if (ifc.rx_done) q_c.push_back({ifc.parity_err, ifc.frame_err, 2'b00, ifc.rx_data});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       ifa.rx = v;
      1:       ifb.rx = v;
      default: ifc.rx = v;
    endcase
  endtask

  task automatic drive_bit(input int ch, input logic v);
    set_rx(ch, v);
    tick(CPB);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input int nb, input bit par_en,
                            input logic pbit, input logic sbit, input int nstop);
    drive_bit(ch, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(ch, d[i]);
    if (par_en) drive_bit(ch, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(ch, sbit);
    set_rx(ch, 1'b1);
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic exp_frame(input int ch, input string tag, input logic [8:0] d,
                           input logic pe, input logic fe);
    logic [10:0] f;
    int n;
    n = qsize(ch);
    chk({tag, "_pulse"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      case (ch)
        0:       f = q_a.pop_front();
        1:       f = q_b.pop_front();
        default: f = q_c.pop_front();
      endcase
      chk({tag, "_data"}, 32'(f[8:0]), 32'(d));
      chk({tag, "_perr"}, 32'(f[10]), 32'(pe));
      chk({tag, "_ferr"}, 32'(f[9]), 32'(fe));
    end
  endtask

  initial begin
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    ifc.rx = 1'b1;
    tick(3);
    chk("rst_data", 32'(ifa.rx_data), 32'h0);
    chk("rst_done", 32'(ifa.rx_done), 32'h0);
    chk("rst_perr", 32'(ifb.parity_err), 32'h0);
    chk("rst_ferr", 32'(ifa.frame_err), 32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'h0);
    rst = 1'b1;
    tick(5);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    tick(4);
    chk("a5_count", 32'(q_a.size()), 32'd1);
    exp_frame(0, "a5", 9'h0A5, 1'b0, 1'b0);
    chk("a5_busy", 32'(ifa.busy), 32'h0);

    // Stop bit low followed by a held-low line: one pulse, then break until high
    send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b0, 1);
    set_rx(0, 1'b0);
    tick(100);
    chk("brk_busy", 32'(ifa.busy), 32'h1);
    set_rx(0, 1'b1);
    tick(20);
    chk("brk_count", 32'(q_a.size()), 32'd1);
    exp_frame(0, "brk", 9'h033, 1'b0, 1'b1);
    chk("brk_idle", 32'(ifa.busy), 32'h0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1);
    tick(4);
    exp_frame(0, "5a", 9'h05A, 1'b0, 1'b0);

    // 4-cycle glitch: rejected at the start-bit check
    set_rx(0, 1'b0);
    tick(4);
    set_rx(0, 1'b1);
    tick(3);
    chk("gl_busy_hi", 32'(ifa.busy), 32'h1);
    tick(8);
    chk("gl_busy_lo", 32'(ifa.busy), 32'h0);
    tick(30);
    chk("gl_count", 32'(q_a.size()), 32'd0);

    // Reset partway through the data bits of 0xFF
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    chk("mid_busy", 32'(ifa.busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", 32'(ifa.rx_data), 32'h0);
    chk("mid_rst_ferr", 32'(ifa.frame_err), 32'h0);
    chk("mid_rst_busy", 32'(ifa.busy), 32'h0);
    chk("mid_rst_done", 32'(ifa.rx_done), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(3 * CPB);
    chk("mid_count", 32'(q_a.size()), 32'd0);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1);
    tick(4);
    exp_frame(0, "81", 9'h081, 1'b0, 1'b0);

    // Back-to-back 8N1 frames with no idle gap
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1);
    tick(4);
    chk("b2b_count", 32'(q_a.size()), 32'd3);
    exp_frame(0, "b2b0", 9'h000, 1'b0, 1'b0);
    exp_frame(0, "b2b1", 9'h0FF, 1'b0, 1'b0);
    exp_frame(0, "b2b2", 9'h055, 1'b0, 1'b0);

    // Even parity: 0x3C has four ones, so the correct parity bit is 0
    send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1);
    tick(4);
    exp_frame(1, "par_bad", 9'h03C, 1'b1, 1'b0);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1'b1, 1);
    tick(4);
    exp_frame(1, "par_ok", 9'h03C, 1'b0, 1'b0);

    // 7O2 back-to-back: odd parity bits 1, 0, 1
    send_frame(2, 9'h000, 7, 1'b1, 1'b1, 1'b1, 2);
    send_frame(2, 9'h07F, 7, 1'b1, 1'b0, 1'b1, 2);
    send_frame(2, 9'h055, 7, 1'b1, 1'b1, 1'b1, 2);
    tick(4);
    chk("c_count", 32'(q_c.size()), 32'd3);
    exp_frame(2, "c0", 9'h000, 1'b0, 1'b0);
    exp_frame(2, "c1", 9'h07F, 1'b0, 1'b0);
    exp_frame(2, "c2", 9'h055, 1'b0, 1'b0);

    tick(10);
    chk("end_qa", 32'(q_a.size()), 32'd0);
    chk("end_qb", 32'(q_b.size()), 32'd0);
    chk("end_qc", 32'(q_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
